// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared sizing helpers for the FIFO read-side adapter.
// Buffer depth is derived from the FIFO read latency.
package fifo_rd_stream_pkg;

    localparam int BUF_SLACK = 2;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int buf_depth(input int rd_lat);
        return rd_lat + BUF_SLACK;
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready output stream of the read adapter.
// The master drives valid and data; the slave drives ready.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 179
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: circular output buffer holding words captured from the FIFO.
// Pushes are credit-limited upstream, so a push never lands on a full buffer.
module fifo_rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 179,
    parameter int DEPTH = 3,
    localparam int PW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop = pop & (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the fixed-latency FIFO_HS read port into a valid/ready stream.
// Credits count buffered plus in-flight words, so every issued read has a slot.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 179,
    parameter int RD_LAT = 1,
    localparam int BUF_DEPTH = buf_depth(RD_LAT),
    localparam int CW = clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_q,
    fifo_rd_stream_if.master strm,
    output logic [CW-1:0]    occupancy
);
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("fifo_rd_stream: RD_LAT must be 1 or 2");
    end

    logic [RD_LAT-1:0] vld_pipe;
    logic [CW-1:0]     count;
    logic [CW:0]       used;
    logic              push;
    logic              pop;

    assign used = (CW+1)'(count) + (CW+1)'($countones(vld_pipe));

    // Issue depends only on registered state, never on out_ready.
    assign fifo_rd_en = rstn & ~fifo_empty & ~flush
                      & (used < (CW+1)'(BUF_DEPTH));

    assign push = vld_pipe[RD_LAT-1] & ~flush;
    assign pop  = strm.out_valid & strm.out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RD_LAT'(fifo_rd_en);
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (flush),
        .push      (push),
        .push_data (fifo_q),
        .pop       (pop),
        .count     (count),
        .head      (strm.out_data)
    );

    assign strm.out_valid = (count != '0);
    assign occupancy      = count;
endmodule
